// File: rtl/transmit_mac_framer_pkg.sv
// Shared types and constants for the GMII transmit framer and its CRC-32 engine.
package transmit_mac_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

    localparam int unsigned BYTE_CNT_W = 11;
    localparam int unsigned CNT_W      = 8;

    // Bit-reverse a 32-bit word; turns the normal polynomial into its LSB-first form.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/transmit_mac_framer_crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step: one data byte, LSB first, reflected register.
module crc32_d8
    import transmit_mac_framer_pkg::*;
(
    input  logic [7:0]  i_data,
    input  logic [31:0] i_crc,
    output logic [31:0] o_crc_c
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    assign o_crc_c = crc_byte(i_crc, i_data);

endmodule

// File: rtl/transmit_mac_framer.sv
// GMII transmit framer: preamble/SFD insertion, optional zero padding, FCS append,
// inter-frame gap and underrun abort, with frame and underrun counters.
module transmit_mac_framer
    import transmit_mac_framer_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_BYTES    = 12,
    parameter int unsigned PAD_EN       = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_data_wr,
    input  logic [7:0]  iv_data,
    input  logic        i_data_last,
    output logic        o_data_ready,
    output logic        o_gmii_tx_en,
    output logic        o_gmii_tx_er,
    output logic [7:0]  ov_gmii_txd,
    output logic [15:0] ov_tx_frame_cnt,
    output logic [15:0] ov_underrun_cnt
);

    localparam logic [BYTE_CNT_W-1:0] MIN_FRAME_W  = BYTE_CNT_W'(MIN_FRAME);
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      PRE_LAST     = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0]      IFG_LAST     = CNT_W'(IFG_BYTES);
    localparam bit                    PAD_ON       = (PAD_EN != 0);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic [31:0]           crc_q, crc_d, crc_next, fcs_word;
    logic [7:0]            crc_din;
    logic                  tx_en_q, tx_en_d;
    logic                  tx_er_q, tx_er_d;
    logic [7:0]            txd_q, txd_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [15:0]           underrun_cnt_q, underrun_cnt_d;

    crc32_d8 u_crc (
        .i_data  (crc_din),
        .i_crc   (crc_q),
        .o_crc_c (crc_next)
    );

    assign crc_din      = (state_q == ST_PAD) ? 8'h00 : iv_data;
    assign fcs_word     = ~crc_q;
    assign o_data_ready = (state_q == ST_SFD) || (state_q == ST_DATA);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            byte_cnt_q     <= '0;
            crc_q          <= CRC_INIT;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            txd_q          <= '0;
            frame_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            crc_q          <= crc_d;
            tx_en_q        <= tx_en_d;
            tx_er_q        <= tx_er_d;
            txd_q          <= txd_d;
            frame_cnt_q    <= frame_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    // cnt_q is shared: preamble bytes sent, FCS byte index, or gap cycles elapsed.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        byte_cnt_d     = byte_cnt_q;
        crc_d          = crc_q;
        tx_en_d        = 1'b0;
        tx_er_d        = 1'b0;
        txd_d          = 8'h00;
        frame_cnt_d    = frame_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        byte_cnt_inc   = (byte_cnt_q == BYTE_CNT_MAX) ? byte_cnt_q : byte_cnt_q + BYTE_CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                crc_d      = CRC_INIT;
                byte_cnt_d = '0;
                cnt_d      = '0;
                if (i_data_wr) begin
                    state_d = ST_PRE;
                    tx_en_d = 1'b1;
                    txd_d   = PREAMBLE_BYTE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q >= PRE_LAST) begin
                    txd_d   = SFD_BYTE;
                    state_d = ST_SFD;
                end else begin
                    txd_d = PREAMBLE_BYTE;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SFD, ST_DATA: begin
                tx_en_d = 1'b1;
                cnt_d   = '0;
                if (i_data_wr) begin
                    txd_d      = iv_data;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                    state_d    = ST_DATA;
                    if (i_data_last) begin
                        state_d = (PAD_ON && (byte_cnt_inc < MIN_FRAME_W)) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Upstream starved mid-frame: flag the error and drop the FCS.
                    tx_er_d        = 1'b1;
                    underrun_cnt_d = underrun_cnt_q + 16'd1;
                    state_d        = ST_IFG;
                end
            end
            ST_PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_next;
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_FRAME_W) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end
            end
            ST_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q[1:0] == 2'd3) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IFG;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IFG: begin
                if (cnt_q >= IFG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_gmii_tx_en    = tx_en_q;
    assign o_gmii_tx_er    = tx_er_q;
    assign ov_gmii_txd     = txd_q;
    assign ov_tx_frame_cnt = frame_cnt_q;
    assign ov_underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_transmit_mac_framer.sv
// Bench for transmit_mac_framer: three parameterisations, output traces compared
// against frames built from byte lists and a software CRC-32.
module tb_transmit_mac_framer;

    localparam int MIN_FRAME = 60;
    localparam int PRE_STD   = 7;
    localparam int IFG_STD   = 12;
    localparam int PRE_SHORT = 3;
    localparam int IFG_SHORT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr   [3];
    logic [7:0]  data [3];
    logic        last [3];
    logic        rdy  [3];
    logic        en   [3];
    logic        er   [3];
    logic [7:0]  txd  [3];
    logic [15:0] fcnt [3];
    logic [15:0] ucnt [3];

    always #4 clk = ~clk;

    // Instance 0: defaults (padding on); 1: padding off; 2: short preamble, long gap.
    transmit_mac_framer u_pad (
        .i_clk(clk), .i_rst(rst), .i_data_wr(wr[0]), .iv_data(data[0]), .i_data_last(last[0]),
        .o_data_ready(rdy[0]), .o_gmii_tx_en(en[0]), .o_gmii_tx_er(er[0]), .ov_gmii_txd(txd[0]),
        .ov_tx_frame_cnt(fcnt[0]), .ov_underrun_cnt(ucnt[0]));

    transmit_mac_framer #(.PAD_EN(0)) u_nopad (
        .i_clk(clk), .i_rst(rst), .i_data_wr(wr[1]), .iv_data(data[1]), .i_data_last(last[1]),
        .o_data_ready(rdy[1]), .o_gmii_tx_en(en[1]), .o_gmii_tx_er(er[1]), .ov_gmii_txd(txd[1]),
        .ov_tx_frame_cnt(fcnt[1]), .ov_underrun_cnt(ucnt[1]));

    transmit_mac_framer #(.PREAMBLE_LEN(PRE_SHORT), .IFG_BYTES(IFG_SHORT)) u_short (
        .i_clk(clk), .i_rst(rst), .i_data_wr(wr[2]), .iv_data(data[2]), .i_data_last(last[2]),
        .o_data_ready(rdy[2]), .o_gmii_tx_en(en[2]), .o_gmii_tx_er(er[2]), .ov_gmii_txd(txd[2]),
        .ov_tx_frame_cnt(fcnt[2]), .ov_underrun_cnt(ucnt[2]));

    int         errors = 0;
    int         checks = 0;
    int         sel = 0;
    logic [9:0] mon_q[$];
    logic [9:0] exp_q[$];

    // Per-cycle trace {tx_en, tx_er, txd} of the instance under test.
    always @(negedge clk) mon_q.push_back({en[sel], er[sel], txd[sel]});

    function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0]  rb;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) rb[k] = b[i][7-k];
            c = c ^ {rb, 24'h000000};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    function automatic logic [9:0] mon_at(input int i);
        if (i >= 0 && i < mon_q.size()) return mon_q[i];
        return 10'h3FF;
    endfunction

    function automatic int find_lead(input int from);
        for (int i = from; i < mon_q.size(); i++) if (mon_q[i][9]) return i;
        return -1;
    endfunction

    function automatic int trace_diff(input int lead);
        if (lead < 0) return 0;
        foreach (exp_q[i]) if (mon_at(lead + i) !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int count_bit(input int bitpos, input int from);
        int n = 0;
        for (int i = from; i < mon_q.size(); i++) if (mon_q[i][bitpos]) n++;
        return n;
    endfunction

    task automatic exp_frame(input int pre, input int min_len, input logic [7:0] pl[$]);
        logic [7:0]  body[$];
        logic [31:0] r;
        body = pl;
        while (body.size() < min_len) body.push_back(8'h00);
        repeat (pre) exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b10, 8'hD5});
        foreach (body[i]) exp_q.push_back({2'b10, body[i]});
        r = ref_crc(body);
        for (int k = 0; k < 4; k++) exp_q.push_back({2'b10, 8'(r >> (8 * k))});
    endtask

    task automatic exp_idle(input int n);
        repeat (n) exp_q.push_back(10'h000);
    endtask

    task automatic start_capture(input int s);
        sel = s;
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic settle();
        repeat (100) @(posedge clk);
        #1;
    endtask

    task automatic make_stream(input logic [7:0] pl[$], output logic ls[$]);
        ls.delete();
        foreach (pl[i]) ls.push_back(i == pl.size() - 1);
    endtask

    task automatic rand_payload(input int n, output logic [7:0] pl[$]);
        pl.delete();
        repeat (n) pl.push_back(8'($urandom));
    endtask

    // Presents bytes until stop_after are accepted; optionally leaves i_data_wr asserted.
    task automatic drive(input int s, input logic [7:0] bytes[$], input logic lasts[$],
                         input int stop_after, input bit keep_wr, output bit timed_out);
        int   idx = 0;
        int   budget = 0;
        logic acc;
        timed_out = 1'b0;
        wr[s] = 1'b1; data[s] = bytes[0]; last[s] = lasts[0];
        while (idx < stop_after) begin
            @(negedge clk);
            acc = rdy[s] & wr[s];
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < bytes.size()) begin
                    data[s] = bytes[idx];
                    last[s] = lasts[idx];
                end
            end
            budget++;
            if (budget > 4000) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (!keep_wr) begin
            wr[s] = 1'b0; last[s] = 1'b0; data[s] = 8'h00;
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({en[s], er[s], txd[s], rdy[s], fcnt[s], ucnt[s]} !== 43'd0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got en=%b er=%b txd=%h rdy=%b fcnt=%0d ucnt=%0d exp all 0",
                         s, en[s], er[s], txd[s], rdy[s], fcnt[s], ucnt[s]);
            end
        end
    endtask

    task automatic test_known_vector();
        logic [7:0]  pl[$];
        logic        ls[$];
        bit          to;
        int          lead, d;
        logic [15:0] f0, u0;
        logic [31:0] fcs;
        pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        make_stream(pl, ls);
        f0 = fcnt[1]; u0 = ucnt[1];
        start_capture(1);
        drive(1, pl, ls, pl.size(), 1'b0, to);
        settle();
        exp_frame(PRE_STD, 0, pl);
        exp_idle(IFG_STD + 3);
        checks++;
        if (to) begin errors++; $display("FAIL kv_timeout got=timeout exp=done"); end
        lead = find_lead(0);
        checks++;
        if (lead !== 1) begin errors++; $display("FAIL kv_latency got=%0d exp=1", lead); end
        d = trace_diff(lead);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL kv_trace idx=%0d got=%h exp=%h", d, mon_at(lead + d), exp_q[d]);
        end
        fcs = {mon_at(lead + 17)[7:0], mon_at(lead + 18)[7:0], mon_at(lead + 19)[7:0], mon_at(lead + 20)[7:0]};
        checks++;
        if (fcs !== 32'h2639_F4CB) begin errors++; $display("FAIL kv_fcs got=%h exp=2639f4cb", fcs); end
        checks++;
        if (count_bit(9, 0) != 21) begin errors++; $display("FAIL kv_txen_len got=%0d exp=21", count_bit(9, 0)); end
        checks++;
        if (16'(fcnt[1] - f0) !== 16'd1) begin errors++; $display("FAIL kv_frame_cnt got=%0d exp=1", 16'(fcnt[1] - f0)); end
        checks++;
        if (ucnt[1] !== u0) begin errors++; $display("FAIL kv_underrun_cnt got=%0d exp=%0d", ucnt[1], u0); end
    endtask

    task automatic test_pad();
        logic [7:0]  pl[$];
        logic        ls[$];
        bit          to;
        int          lead, d, n;
        logic [15:0] f0;
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(i));
        make_stream(pl, ls);
        f0 = fcnt[0];
        start_capture(0);
        drive(0, pl, ls, pl.size(), 1'b0, to);
        settle();
        exp_frame(PRE_STD, MIN_FRAME, pl);
        exp_idle(IFG_STD + 3);
        checks++;
        if (to) begin errors++; $display("FAIL pad_timeout got=timeout exp=done"); end
        lead = find_lead(0);
        d = trace_diff(lead);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL pad_trace idx=%0d got=%h exp=%h", d, mon_at(lead + d), exp_q[d]);
        end
        n = count_bit(9, lead + PRE_STD + 1);
        checks++;
        if (n != 64) begin errors++; $display("FAIL pad_len_after_sfd got=%0d exp=64", n); end
        checks++;
        if (16'(fcnt[0] - f0) !== 16'd1) begin errors++; $display("FAIL pad_frame_cnt got=%0d exp=1", 16'(fcnt[0] - f0)); end
    endtask

    task automatic test_random();
        logic [7:0]  pl[$];
        logic        ls[$];
        bit          to;
        int          lead, d, s, len;
        logic [15:0] f0;
        for (int n = 0; n < 6; n++) begin
            s   = n % 2;
            len = int'($urandom_range(80, 1));
            rand_payload(len, pl);
            make_stream(pl, ls);
            f0 = fcnt[s];
            start_capture(s);
            drive(s, pl, ls, pl.size(), 1'b0, to);
            settle();
            exp_frame(PRE_STD, (s == 0) ? MIN_FRAME : 0, pl);
            exp_idle(IFG_STD + 3);
            lead = find_lead(0);
            d = trace_diff(lead);
            checks++;
            if (to || d != -1) begin
                errors++;
                $display("FAIL rand_trace frame=%0d inst=%0d len=%0d idx=%0d got=%h exp=%h",
                         n, s, len, d, mon_at(lead + d), (d >= 0) ? exp_q[d] : 10'h000);
            end
            checks++;
            if (16'(fcnt[s] - f0) !== 16'd1) begin
                errors++;
                $display("FAIL rand_frame_cnt frame=%0d got=%0d exp=1", n, 16'(fcnt[s] - f0));
            end
        end
    endtask

    task automatic test_back_to_back(input int s, input int pre, input int ifg);
        logic [7:0]  p1[$];
        logic [7:0]  p2[$];
        logic [7:0]  all[$];
        logic        ls[$];
        bit          to;
        int          lead, d, gap, idx, npre;
        logic [15:0] f0;
        rand_payload(60, p1);
        rand_payload(60, p2);
        all = {p1, p2};
        ls.delete();
        foreach (all[i]) ls.push_back(i == 59 || i == 119);
        f0 = fcnt[s];
        start_capture(s);
        drive(s, all, ls, all.size(), 1'b0, to);
        settle();
        exp_frame(pre, MIN_FRAME, p1);
        exp_idle(ifg + 1);
        exp_frame(pre, MIN_FRAME, p2);
        exp_idle(ifg + 3);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout inst=%0d got=timeout exp=done", s); end
        lead = find_lead(0);
        checks++;
        if (lead !== 1) begin errors++; $display("FAIL b2b_latency inst=%0d got=%0d exp=1", s, lead); end
        npre = 0;
        while (mon_at(lead + npre) === {2'b10, 8'h55}) npre++;
        checks++;
        if (npre != pre) begin errors++; $display("FAIL b2b_preamble inst=%0d got=%0d exp=%0d", s, npre, pre); end
        idx = lead + pre + 1 + 60 + 4;
        gap = find_lead(idx) - idx;
        checks++;
        if (gap != ifg + 1) begin errors++; $display("FAIL b2b_gap inst=%0d got=%0d exp=%0d", s, gap, ifg + 1); end
        d = trace_diff(lead);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL b2b_trace inst=%0d idx=%0d got=%h exp=%h", s, d, mon_at(lead + d), exp_q[d]);
        end
        checks++;
        if (16'(fcnt[s] - f0) !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt inst=%0d got=%0d exp=2", s, 16'(fcnt[s] - f0)); end
    endtask

    task automatic test_underrun();
        logic [7:0]  pl[$];
        logic [7:0]  head[$];
        logic        ls[$];
        bit          to;
        int          lead, d;
        logic [15:0] f0, u0;
        rand_payload(60, pl);
        make_stream(pl, ls);
        f0 = fcnt[0]; u0 = ucnt[0];
        start_capture(0);
        drive(0, pl, ls, 10, 1'b0, to);
        settle();
        head = pl[0:9];
        repeat (PRE_STD) exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b10, 8'hD5});
        foreach (head[i]) exp_q.push_back({2'b10, head[i]});
        exp_q.push_back({2'b11, 8'h00});
        exp_idle(IFG_STD + 3);
        lead = find_lead(0);
        d = trace_diff(lead);
        checks++;
        if (to || d != -1) begin
            errors++;
            $display("FAIL ur_trace idx=%0d got=%h exp=%h", d, mon_at(lead + d), (d >= 0) ? exp_q[d] : 10'h000);
        end
        checks++;
        if (count_bit(8, 0) != 1) begin errors++; $display("FAIL ur_txer_cycles got=%0d exp=1", count_bit(8, 0)); end
        checks++;
        if (16'(ucnt[0] - u0) !== 16'd1) begin errors++; $display("FAIL ur_underrun_cnt got=%0d exp=1", 16'(ucnt[0] - u0)); end
        checks++;
        if (fcnt[0] !== f0) begin errors++; $display("FAIL ur_frame_cnt got=%0d exp=%0d", fcnt[0], f0); end
        // The next frame must go out intact.
        rand_payload(30, pl);
        make_stream(pl, ls);
        start_capture(0);
        drive(0, pl, ls, pl.size(), 1'b0, to);
        settle();
        exp_frame(PRE_STD, MIN_FRAME, pl);
        exp_idle(IFG_STD + 3);
        lead = find_lead(0);
        d = trace_diff(lead);
        checks++;
        if (to || lead !== 1 || d != -1) begin
            errors++;
            $display("FAIL ur_recovery lead=%0d idx=%0d got=%h exp=%h", lead, d, mon_at(lead + d), (d >= 0) ? exp_q[d] : 10'h000);
        end
    endtask

    task automatic test_idle_last();
        start_capture(0);
        last[0] = 1'b1;
        data[0] = 8'hA5;
        repeat (20) @(posedge clk);
        #1;
        last[0] = 1'b0;
        data[0] = 8'h00;
        checks++;
        if (count_bit(9, 0) != 0) begin errors++; $display("FAIL idle_last_ignored got=%0d tx_en cycles exp=0", count_bit(9, 0)); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pl[$];
        logic       ls[$];
        bit         to;
        int         lead, d;
        rand_payload(60, pl);
        make_stream(pl, ls);
        start_capture(0);
        drive(0, pl, ls, 30, 1'b1, to);
        checks++;
        if (to || en[0] !== 1'b1 || txd[0] !== pl[29]) begin
            errors++;
            $display("FAIL rm_byte30 got en=%b txd=%h exp en=1 txd=%h", en[0], txd[0], pl[29]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({en[0], er[0], txd[0], rdy[0], fcnt[0], ucnt[0]} !== 43'd0) begin
            errors++;
            $display("FAIL rm_async_clear got en=%b er=%b txd=%h rdy=%b fcnt=%0d ucnt=%0d exp all 0",
                     en[0], er[0], txd[0], rdy[0], fcnt[0], ucnt[0]);
        end
        wr[0] = 1'b0; last[0] = 1'b0; data[0] = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rand_payload(45, pl);
        make_stream(pl, ls);
        start_capture(0);
        drive(0, pl, ls, pl.size(), 1'b0, to);
        settle();
        exp_frame(PRE_STD, MIN_FRAME, pl);
        exp_idle(IFG_STD + 3);
        lead = find_lead(0);
        d = trace_diff(lead);
        checks++;
        if (to || lead !== 1 || d != -1) begin
            errors++;
            $display("FAIL rm_next_frame lead=%0d idx=%0d got=%h exp=%h", lead, d, mon_at(lead + d), (d >= 0) ? exp_q[d] : 10'h000);
        end
        checks++;
        if (fcnt[0] !== 16'd1 || ucnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL rm_counters got fcnt=%0d ucnt=%0d exp fcnt=1 ucnt=0", fcnt[0], ucnt[0]);
        end
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wr[s] = 1'b0; data[s] = 8'h00; last[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_known_vector();
        test_pad();
        test_random();
        test_back_to_back(0, PRE_STD, IFG_STD);
        test_back_to_back(2, PRE_SHORT, IFG_SHORT);
        test_underrun();
        test_idle_last();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
